mem_port_arbiter: RTL

Arbitrates the unified single-ported instruction/data `Memory` between the IF-stage fetch port and the MEM-stage load/store port. Drives the memory's control and address inputs every cycle and grants one or both requesters. Registers returned instruction and load data into one-cycle-latency response outputs. Includes an anti-starvation counter, so a stream of loads cannot stall fetch indefinitely.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-ported memory between instruction fetch and load/store,
// with a starvation guard that forces one fetch cycle after a run of loads.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [5:0]  fetch_addr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [5:0]  data_addr,
  input  logic [2:0]  data_funct3,
  input  logic [31:0] data_wdata,
  input  logic [31:0] mem_data_out,
  input  logic [31:0] mem_instruction,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_inst_addr,
  output logic [5:0]  mem_data_addr,
  output logic [31:0] mem_data_in,
  output logic [2:0]  mem_funct3,
  output logic        fetch_gnt,
  output logic        data_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [5:0]  fetch_pc_q,
  output logic        load_valid,
  output logic [31:0] load_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(STARVE_LIMIT);

  typedef enum logic {NORMAL, FORCE_FETCH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          is_load, is_store;
  logic          fetch_valid_q, load_valid_q;
  logic [31:0]   fetch_instr_q, load_data_q;
  logic [5:0]    pc_q;

  assign is_load  = data_req & ~data_we;
  assign is_store = data_req & data_we;
  assign cnt_inc  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

  // Stores never touch the instruction port, so only loads compete with fetch.
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!rst) begin
      if (state_q == FORCE_FETCH) begin
        fetch_gnt = fetch_req;
        data_gnt  = is_store;
      end else begin
        data_gnt  = data_req;
        fetch_gnt = fetch_req & ~is_load;
      end
    end
  end

  assign mem_read      = data_gnt & ~data_we;
  assign mem_write     = data_gnt & data_we;
  assign mem_inst_addr = fetch_addr;
  assign mem_data_addr = data_addr;
  assign mem_data_in   = data_wdata;
  assign mem_funct3    = data_funct3;

  // The forced fetch lasts exactly one cycle; the counter only runs while fetch is being starved.
  always_comb begin
    state_d = NORMAL;
    cnt_d   = cnt_q;
    if (fetch_gnt || !fetch_req) begin
      cnt_d = '0;
    end else if (mem_read) begin
      if (cnt_inc == LIMIT) begin
        state_d = FORCE_FETCH;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= NORMAL;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      load_valid_q  <= 1'b0;
      fetch_instr_q <= '0;
      pc_q          <= '0;
      load_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fetch_valid_q <= fetch_gnt;
      load_valid_q  <= mem_read;
      if (fetch_gnt) begin
        fetch_instr_q <= mem_instruction;
        pc_q          <= fetch_addr;
      end
      if (mem_read) begin
        load_data_q <= mem_data_out;
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_pc_q  = pc_q;
  assign load_valid  = load_valid_q;
  assign load_data   = load_data_q;

endmodule
